// File: rtl/sram_arb_pkg.sv
// Purpose : shared types and constants for the SRAM access arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

  // Access sequencer states; every non-IDLE state counts as busy.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    WRITE,
    HOLD,
    DONE
  } arb_state_t;

  // Owner encoding, also used as the requester index into the round-robin.
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Purpose : two-way round-robin grant with a registered last-grant pointer.
// Latency : grant is combinational; the pointer updates on the clock edge of a granted cycle.
// Backpressure: the caller qualifies grants with gnt_en_i; ungranted requests are simply re-presented.
// Ports   : clk_i/rst_ni clock and async active-low reset; req_i[1:0] requests;
//           gnt_en_i accept a grant this cycle; gnt_vld_o any request present;
//           gnt_idx_o winning requester index.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       gnt_en_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = OWN_CPU;
    unique case (req_i)
      2'b01:   gnt_idx_o = OWN_CPU;
      2'b10:   gnt_idx_o = OWN_LDR;
      2'b11:   gnt_idx_o = ~last_q;  // tie goes to whoever did not win last
      default: gnt_idx_o = OWN_CPU;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (gnt_en_i && gnt_vld_o) begin
      last_d = gnt_idx_o;
    end
  end

  // Resetting to the loader makes the CPU the winner of the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= OWN_LDR;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Purpose : owns the shared SRAM, arbitrates CPU vs loader and sequences OE/WE timing.
// Latency : read ack RD_CYCLES+3 cycles, write ack WR_CYCLES+4 cycles, counting the IDLE sample cycle.
// Backpressure: level requests wait in IDLE until granted; a requester holds its request until its ack pulse.
// Ports   : Clk/Reset; cpu_* and ldr_* request ports (req/we/addr/wdata in, rdata/ack out);
//           ADDR, Data_to_SRAM, Data_oe, Data_from_SRAM, Mem_CE/UB/LB/OE/WE to the SRAM;
//           owner/busy status.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  output logic              Data_oe,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              owner,
  output logic              busy
);

  localparam int CNT_W = $clog2(max2(RD_CYCLES, WR_CYCLES)) + 1;

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              doe_q, doe_d;

  logic gnt_vld;
  logic gnt_idx;

  rr_arbiter2 u_rr (
    .clk_i     (Clk),
    .rst_ni    (Reset),
    .req_i     ({ldr_req, cpu_req}),
    .gnt_en_i  (state_q == IDLE),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    owner_d     = owner_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_idx;
          if (gnt_idx == OWN_LDR) begin
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
            we_d    = ldr_we;
          end else begin
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            we_d    = cpu_we;
          end
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (we_q) begin
          state_d = WRITE;
          cnt_d   = CNT_W'(WR_CYCLES - 1);
        end else begin
          state_d = READ;
          cnt_d   = CNT_W'(RD_CYCLES - 1);
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          // OE has been low for the full window; the bus is valid now.
          if (owner_q == OWN_LDR) ldr_rdata_d = Data_from_SRAM;
          else                    cpu_rdata_d = Data_from_SRAM;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they switch cleanly with it.
    oe_n_d = (state_d != READ);
    we_n_d = (state_d != WRITE);
    doe_d  = we_d && ((state_d == SETUP) || (state_d == WRITE) || (state_d == HOLD));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      owner_q     <= OWN_CPU;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      doe_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      doe_q       <= doe_d;
    end
  end

  assign cpu_ack      = (state_q == DONE) && (owner_q == OWN_CPU);
  assign ldr_ack      = (state_q == DONE) && (owner_q == OWN_LDR);
  assign cpu_rdata    = cpu_rdata_q;
  assign ldr_rdata    = ldr_rdata_q;
  assign ADDR         = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign Data_oe      = doe_q;
  assign Mem_OE       = oe_n_q;
  assign Mem_WE       = we_n_q;
  assign Mem_CE       = 1'b0;
  assign Mem_UB       = 1'b0;
  assign Mem_LB       = 1'b0;
  assign owner        = owner_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Purpose : scoreboard bench for sram_access_arbiter (default timing and RD=1/WR=3 instances).
// Latency : drivers push expected responses; a negedge monitor pops them on every ack.
// Backpressure: drivers hold each request until its ack, with a bounded wait.
module tb_sram_access_arbiter;

  typedef struct {
    bit          we;
    logic [15:0] rdata;
    int          lat;
    int          t0;
  } exp_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset;
  int   cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Request index = dut*2 + port (port 0 = cpu, 1 = ldr).
  logic [3:0]  req_v, we_v;
  logic [19:0] addr_v  [4];
  logic [15:0] wdata_v [4];
  wire  [3:0]  ack_v;
  wire  [15:0] rdata_v [4];

  wire  [19:0] adr0, adr1;
  wire  [15:0] dts0, dts1;
  logic [15:0] dfs0, dfs1;
  wire doe0, doe1, ce0, ce1, ub0, ub1, lb0, lb1, oe0, oe1, wn0, wn1;
  wire own0, own1, busy0, busy1;

  sram_access_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(req_v[0]), .cpu_we(we_v[0]), .cpu_addr(addr_v[0]), .cpu_wdata(wdata_v[0]),
    .cpu_rdata(rdata_v[0]), .cpu_ack(ack_v[0]),
    .ldr_req(req_v[1]), .ldr_we(we_v[1]), .ldr_addr(addr_v[1]), .ldr_wdata(wdata_v[1]),
    .ldr_rdata(rdata_v[1]), .ldr_ack(ack_v[1]),
    .ADDR(adr0), .Data_to_SRAM(dts0), .Data_oe(doe0), .Data_from_SRAM(dfs0),
    .Mem_CE(ce0), .Mem_UB(ub0), .Mem_LB(lb0), .Mem_OE(oe0), .Mem_WE(wn0),
    .owner(own0), .busy(busy0)
  );

  sram_access_arbiter #(.RD_CYCLES(1), .WR_CYCLES(3)) dut2 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(req_v[2]), .cpu_we(we_v[2]), .cpu_addr(addr_v[2]), .cpu_wdata(wdata_v[2]),
    .cpu_rdata(rdata_v[2]), .cpu_ack(ack_v[2]),
    .ldr_req(req_v[3]), .ldr_we(we_v[3]), .ldr_addr(addr_v[3]), .ldr_wdata(wdata_v[3]),
    .ldr_rdata(rdata_v[3]), .ldr_ack(ack_v[3]),
    .ADDR(adr1), .Data_to_SRAM(dts1), .Data_oe(doe1), .Data_from_SRAM(dfs1),
    .Mem_CE(ce1), .Mem_UB(ub1), .Mem_LB(lb1), .Mem_OE(oe1), .Mem_WE(wn1),
    .owner(own1), .busy(busy1)
  );

  // SRAM models: write while WE is low, read data always presented for ADDR.
  logic [15:0] mem0 [1024];
  logic [15:0] mem1 [1024];
  logic        pre_we;
  logic [9:0]  pre_a;
  logic [15:0] pre_d;

  always @(posedge Clk) begin
    if (pre_we)   mem0[pre_a] <= pre_d;
    else if (!wn0) mem0[adr0[9:0]] <= dts0;
    if (!wn1)     mem1[adr1[9:0]] <= dts1;
  end
  assign dfs0 = mem0[adr0[9:0]];
  assign dfs1 = mem1[adr1[9:0]];

  assert property (@(posedge Clk) disable iff (!Reset) !(!oe0 && !wn0));
  assert property (@(posedge Clk) disable iff (!Reset) !(!oe1 && !wn1));

  int   checks = 0;
  int   errors = 0;
  exp_t sbq [4][$];
  int   ack_cnt [4];
  int   order_log [$];
  int   oe_lo = 0, we_lo = 0, doe_hi = 0, addr_bad = 0, viol = 0;
  logic [19:0] addr_watch = '0;
  logic [15:0] model [2][8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and tracks strobe activity.
  always @(negedge Clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (ack_v[i] === 1'b1) begin
        ack_cnt[i]++;
        if (i < 2) order_log.push_back(i);
        if (sbq[i].size() == 0) begin
          chk($sformatf("unexpected_ack_%0d", i), 32'd1, 32'd0);
        end else begin
          e = sbq[i].pop_front();
          if (!e.we) chk($sformatf("rdata_%0d", i), {16'd0, rdata_v[i]}, {16'd0, e.rdata});
          if (e.lat != 0) chk($sformatf("latency_%0d", i), cyc - e.t0 + 1, e.lat);
        end
      end
    end
    if (Reset) begin
      if ((!oe0 && !wn0) || (doe0 && !oe0) || (ack_v[0] && ack_v[1])) viol++;
      if ((!oe1 && !wn1) || (doe1 && !oe1) || (ack_v[2] && ack_v[3])) viol++;
      if (!oe0) oe_lo++;
      if (!wn0) we_lo++;
      if (doe0) doe_hi++;
      if (busy0 && adr0 !== addr_watch) addr_bad++;
    end
  end

  task automatic access(input int d, input int p, input bit w, input logic [19:0] a,
                        input logic [15:0] wd, input logic [15:0] rd, input int lat,
                        input bit extra);
    int   i;
    exp_t e;
    bit   got;
    i = d * 2 + p;
    @(posedge Clk); #1;
    e.we = w; e.rdata = rd; e.lat = lat; e.t0 = cyc;
    sbq[i].push_back(e);
    if (extra) begin
      e.lat = 0;
      sbq[i].push_back(e);
    end
    we_v[i] = w; addr_v[i] = a; wdata_v[i] = wd; req_v[i] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge Clk);
      if (ack_v[i] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout_%0d: got no ack expected ack", i);
    end
    if (extra) begin
      // Leave req high into the next IDLE cycle so it is taken as a new access.
      @(posedge Clk); @(posedge Clk); #1;
    end
    req_v[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge Clk);
      ok = !busy0 && !busy1 && sbq[0].size() == 0 && sbq[1].size() == 0 &&
           sbq[2].size() == 0 && sbq[3].size() == 0;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
  endtask

  task automatic rand_port(input int p);
    int          idx;
    bit          w;
    logic [15:0] dat;
    logic [19:0] a;
    for (int n = 0; n < 500; n++) begin
      idx = (n < 8) ? n : int'($urandom_range(0, 7));
      w   = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      dat = 16'($urandom);
      a   = {10'd0, 1'(p), 6'd0, 3'(idx)};
      if (w) begin
        model[p][idx] = dat;
        access(1, p, 1'b1, a, dat, 16'h0, 0, 1'b0);
      end else begin
        access(1, p, 1'b0, a, 16'h0, model[p][idx], 0, 1'b0);
      end
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end
  endtask

  initial begin
    int s0, s1, s2, base;
    Reset = 1'b0; req_v = '0; we_v = '0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    for (int i = 0; i < 4; i++) begin addr_v[i] = '0; wdata_v[i] = '0; ack_cnt[i] = 0; end
    repeat (3) @(negedge Clk);

    // Reset state
    chk("rst_Mem_OE", oe0, 1);  chk("rst_Mem_WE", wn0, 1);
    chk("rst_Data_oe", doe0, 0); chk("rst_busy", busy0, 0);
    chk("rst_ADDR", adr0, 0);   chk("rst_Data_to_SRAM", dts0, 0);
    chk("rst_owner", own0, 0);  chk("rst_acks", ack_v, 0);
    chk("rst_cpu_rdata", rdata_v[0], 0); chk("rst_ldr_rdata", rdata_v[1], 0);
    chk("rst_Mem_CE", {ce0, ub0, lb0}, 0);

    pre_we = 1'b1; pre_a = 10'h012; pre_d = 16'h1234;
    @(negedge Clk);
    pre_we = 1'b0; Reset = 1'b1;

    // CPU read
    s0 = oe_lo;
    access(0, 0, 1'b0, 20'h00012, 16'h0, 16'h1234, 5, 1'b0);
    wait_idle();
    chk("read_oe_low_cycles", oe_lo - s0, 2);
    chk("ldr_ack_during_cpu_read", ack_cnt[1], 0);
    chk("cpu_single_ack", ack_cnt[0], 1);

    // Loader write then CPU read-back
    addr_watch = 20'h00100;
    s0 = we_lo; s1 = doe_hi; s2 = addr_bad;
    access(0, 1, 1'b1, 20'h00100, 16'hBEEF, 16'h0, 6, 1'b0);
    wait_idle();
    chk("write_we_low_cycles", we_lo - s0, 2);
    chk("write_doe_cycles", doe_hi - s1, 4);
    chk("write_addr_stable", addr_bad - s2, 0);
    chk("cpu_rdata_held", rdata_v[0], 16'h1234);
    access(0, 0, 1'b0, 20'h00100, 16'h0, 16'hBEEF, 5, 1'b0);
    wait_idle();

    // Request held one cycle past ack starts a second access
    s0 = ack_cnt[0];
    access(0, 0, 1'b0, 20'h00012, 16'h0, 16'h1234, 0, 1'b1);
    wait_idle();
    chk("held_req_ack_count", ack_cnt[0] - s0, 2);

    // Round-robin after a fresh reset
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    base = order_log.size();
    fork
      begin
        access(0, 0, 1'b0, 20'h00012, 16'h0, 16'h1234, 0, 1'b0);
        access(0, 0, 1'b0, 20'h00012, 16'h0, 16'h1234, 0, 1'b0);
      end
      begin
        access(0, 1, 1'b0, 20'h00100, 16'h0, 16'hBEEF, 0, 1'b0);
        access(0, 1, 1'b0, 20'h00100, 16'h0, 16'hBEEF, 0, 1'b0);
      end
    join
    wait_idle();
    chk("rr_ack_count", order_log.size() - base, 4);
    if (order_log.size() >= base + 4) begin
      chk("rr_grant0", order_log[base],     0);
      chk("rr_grant1", order_log[base + 1], 1);
      chk("rr_grant2", order_log[base + 2], 0);
      chk("rr_grant3", order_log[base + 3], 1);
    end

    // Reset in the middle of a write
    @(posedge Clk); #1;
    we_v[1] = 1'b1; addr_v[1] = 20'h00040; wdata_v[1] = 16'h5555; req_v[1] = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge Clk);
        if (wn0 === 1'b0) seen = 1'b1;
      end
      chk("abort_we_reached", seen, 1);
    end
    Reset = 1'b0;
    #1;
    chk("abort_Mem_WE", wn0, 1);
    chk("abort_Data_oe", doe0, 0);
    chk("abort_busy", busy0, 0);
    req_v[1] = 1'b0;
    s0 = ack_cnt[0] + ack_cnt[1];
    @(negedge Clk); Reset = 1'b1;
    repeat (10) @(negedge Clk);
    chk("abort_no_ack", ack_cnt[0] + ack_cnt[1] - s0, 0);

    // RD_CYCLES=1 / WR_CYCLES=3 latencies
    model[0][5] = 16'hA5A5;
    access(1, 0, 1'b1, 20'h00005, 16'hA5A5, 16'h0, 7, 1'b0);
    wait_idle();
    access(1, 0, 1'b0, 20'h00005, 16'h0, 16'hA5A5, 4, 1'b0);
    wait_idle();

    // Random two-port stream on the short-timing instance
    fork
      rand_port(0);
      rand_port(1);
    join
    wait_idle();
    chk("rand_ack_total", ack_cnt[2] + ack_cnt[3], 1002);
    chk("protocol_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Owns the single shared SRAM and sequences every access to it with the multi-cycle OE/WE timing the SRAM requires.
- Shares the SRAM between two requesters: port 0 is the CPU MAR/MDR path under ISDU control, port 1 is the program loader/debug front panel.
- Replaces the ISDU's direct Mem_OE/Mem_WE driving. The ISDU raises a request and waits for ack instead of counting fixed wait states.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- RD_CYCLES, 2, cycles Mem_OE is held low per read (≥1).
- WR_CYCLES, 2, cycles Mem_WE is held low per write (≥1).

Ports:
- Clk in 1 system clock, rising edge.
- Reset in 1 asynchronous, active-low reset.
- cpu_req in 1 CPU access request, level.
- cpu_we in 1 1=write, 0=read.
- cpu_addr in ADDR_W CPU address.
- cpu_wdata in DATA_W CPU write data.
- cpu_rdata out DATA_W read data, valid while cpu_ack=1.
- cpu_ack out 1 one-cycle completion pulse.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack: loader port, same widths and meanings as the cpu_* ports.
- ADDR out ADDR_W SRAM address.
- Data_to_SRAM out DATA_W write data.
- Data_oe out 1 1=drive the SRAM data bus (top-level tristate enable).
- Data_from_SRAM in DATA_W SRAM read data.
- Mem_CE, Mem_UB, Mem_LB out 1 each, tied 0 (active-low).
- Mem_OE, Mem_WE out 1 each, active-low, registered.
- owner out 1 port currently granted (0=cpu, 1=ldr), valid when busy=1.
- busy out 1 1 whenever state≠IDLE.

Behaviour:
- Reset asserted (Reset=0), asynchronously:
  - state=IDLE; Mem_OE=1, Mem_WE=1, Data_oe=0.
  - cpu_ack=ldr_ack=0; rdata regs=0; ADDR=0; Data_to_SRAM=0; owner=0; busy=0.
  - last_grant=1, so the CPU wins the first tie.
- Reset mid-access aborts at once (Mem_WE/OE return high asynchronously). No ack is issued.
- States: IDLE, SETUP, READ, WRITE, HOLD, DONE.
- IDLE:
  - Requests are sampled only here.
  - Neither req → stay in IDLE.
  - One req → grant it.
  - Both req → grant the port ≠ last_grant (round-robin).
  - On grant: latch addr, we and wdata of the winner into ADDR/Data_to_SRAM; set owner and last_grant; go to SETUP.
- SETUP: 1 cycle, address stable, OE=WE=1. Next state READ if we=0, else WRITE. Data_oe=1 from SETUP for writes.
- READ: Mem_OE=0 for RD_CYCLES cycles (down-counter). On the last cycle, latch Data_from_SRAM into the owner's rdata reg. Then go to DONE.
- WRITE: Mem_WE=0, Data_oe=1 for WR_CYCLES cycles, then go to HOLD.
- HOLD: 1 cycle, WE=1, Data_oe=1, address and data still stable. Then go to DONE.
- DONE: 1 cycle. The owner's ack=1; the other ack stays 0; OE=WE=1, Data_oe=0. Then go to IDLE.
- Latency from request seen in IDLE to ack:
  - read: 1+1+RD_CYCLES+1 cycles (5 at defaults);
  - write: 1+1+WR_CYCLES+1+1 cycles (6 at defaults).
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until its ack.
  - It must drop req in the ack cycle. Req still high in the following IDLE cycle is treated as a new access.
  - rdata holds its value until that port's next read completes.
- A request arriving while busy waits; it is not lost because req is level-sensitive.
- Mem_OE and Mem_WE are never low in the same cycle. Data_oe and Mem_OE=0 are never both active.
- Address/data change only in IDLE→SETUP, never while OE or WE is low.
- Counter width is $clog2(max(RD_CYCLES,WR_CYCLES))+1. It reloads on entry to READ/WRITE; there is no wrap.

Decomposition:
- Package sram_arb_pkg: arb_state_t enum (IDLE, SETUP, READ, WRITE, HOLD, DONE); owner constants OWN_CPU=1'b0, OWN_LDR=1'b1.
- Sub-module rr_arbiter2: combinational grant plus registered last_grant, updated on grant. Inputs req[1:0] and a grant-enable; outputs the winner index.
- The FSM, counter and datapath registers stay in sram_access_arbiter.

Test Plan:
- Reset=0 during WRITE with Mem_WE=0 → same-cycle Mem_WE=1, Data_oe=0, busy=0; after release, no ack is seen.
- CPU read, addr=0x00012, SRAM returns 0x1234 → Mem_OE low exactly 2 cycles; cpu_ack pulses 5 cycles after req with cpu_rdata=0x1234; ldr_ack stays 0.
- Loader write, addr=0x00100, data=0xBEEF → ADDR stable across SETUP..HOLD; Mem_WE low 2 cycles; Data_oe high 4 cycles; ldr_ack at cycle 6. A subsequent CPU read of 0x00100 returns 0xBEEF.
- cpu_req and ldr_req both held high for 4 accesses after reset → grant order cpu, ldr, cpu, ldr.
- CPU keeps req high one cycle past ack → a second full access starts; a bench with correct deassertion gets exactly one ack.
- Set RD_CYCLES=1, WR_CYCLES=3 → read ack at 4 cycles, write ack at 7; OE and WE never low together (assertion over a random 1000-request stream).
